// File: rtl/imuldiv_pkg.sv
// imuldiv_pkg -- shared encodings for the integer multiply/divide blocks.
//   FN_*  : mulreq_msg_fn operand-signedness encodings (2'b11 aliases FN_UU)
//   ST_*  : controller state encodings
//   a_is_signed / b_is_signed : decode which operands carry a sign for a fn
package imuldiv_pkg;

   localparam logic [1:0] FN_SS = 2'b00;
   localparam logic [1:0] FN_UU = 2'b01;
   localparam logic [1:0] FN_SU = 2'b10;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_CALC = 2'b01;
   localparam logic [1:0] ST_DONE = 2'b10;

   function automatic logic a_is_signed(input logic [1:0] fn);
      return (fn == FN_SS) || (fn == FN_SU);
   endfunction

   function automatic logic b_is_signed(input logic [1:0] fn);
      return (fn == FN_SS);
   endfunction

endpackage

// File: rtl/imuldiv_int_mul_var_dpath.sv
// imuldiv_int_mul_var_dpath -- shift-and-add datapath for the iterative multiplier.
//   clk, reset      : clock, synchronous active-high reset (clears all state)
//   load            : capture operand magnitudes / sign flags, clear acc and count
//   calc            : perform one shift-and-add iteration
//   a_in, b_in, fn_in : request operands and signedness select
//   b_rest_zero     : multiplier bits remaining after this iteration are all zero
//   count_last      : this iteration is number W-1
//   result          : signed-corrected 2W-bit product of the accumulator
module imuldiv_int_mul_var_dpath
   import imuldiv_pkg::*;
#(
   parameter int W = 32
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           load,
   input  logic           calc,
   input  logic [W-1:0]   a_in,
   input  logic [W-1:0]   b_in,
   input  logic [1:0]     fn_in,
   output logic           b_rest_zero,
   output logic           count_last,
   output logic [2*W-1:0] result
);

   localparam int CW = $clog2(W);

   logic [2*W-1:0] a_q, a_d, acc_q, acc_d;
   logic [W-1:0]   b_q, b_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           sa_q, sa_d, sb_q, sb_d;
   logic           a_neg, b_neg;
   logic [W-1:0]   mag_a, mag_b;

   always_comb begin
      a_neg = a_is_signed(fn_in) & a_in[W-1];
      b_neg = b_is_signed(fn_in) & b_in[W-1];
      // Negating the most-negative value wraps back to 2^(W-1), which is
      // exactly the magnitude when read as unsigned.
      mag_a = a_neg ? -a_in : a_in;
      mag_b = b_neg ? -b_in : b_in;

      a_d   = a_q;
      b_d   = b_q;
      acc_d = acc_q;
      cnt_d = cnt_q;
      sa_d  = sa_q;
      sb_d  = sb_q;
      if (load) begin
         a_d   = {{W{1'b0}}, mag_a};
         b_d   = mag_b;
         acc_d = '0;
         cnt_d = '0;
         sa_d  = a_neg;
         sb_d  = b_neg;
      end else if (calc) begin
         if (b_q[0]) acc_d = acc_q + a_q;
         a_d   = a_q << 1;
         b_d   = b_q >> 1;
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
         cnt_q <= '0;
         sa_q  <= 1'b0;
         sb_q  <= 1'b0;
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         acc_q <= acc_d;
         cnt_q <= cnt_d;
         sa_q  <= sa_d;
         sb_q  <= sb_d;
      end
   end

   // Evaluated on the current b_q: true when the post-shift value is zero.
   assign b_rest_zero = (b_q[W-1:1] == '0);
   assign count_last  = (cnt_q == CW'(W-1));
   assign result      = (sa_q ^ sb_q) ? -acc_q : acc_q;

endmodule

// File: rtl/imuldiv_int_mul_var.sv
// imuldiv_int_mul_var -- iterative (one bit per cycle) integer multiplier with
// optional early termination and val/rdy request/response handshakes.
//   clk, reset          : clock, synchronous active-high reset
//   mulreq_msg_a/b      : W-bit multiplicand / multiplier
//   mulreq_msg_fn       : 00 SxS, 01 UxU, 10 S(a)xU(b), 11 as 01
//   mulreq_val/rdy      : request handshake (rdy only in IDLE)
//   mulresp_msg_result  : 2W-bit product
//   mulresp_val/rdy     : response handshake (val only in DONE)
module imuldiv_int_mul_var
   import imuldiv_pkg::*;
#(
   parameter int W          = 32,
   parameter int EARLY_TERM = 1
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [W-1:0]   mulreq_msg_a,
   input  logic [W-1:0]   mulreq_msg_b,
   input  logic [1:0]     mulreq_msg_fn,
   input  logic           mulreq_val,
   output logic           mulreq_rdy,
   output logic [2*W-1:0] mulresp_msg_result,
   output logic           mulresp_val,
   input  logic           mulresp_rdy
);

   logic [1:0] state_q, state_d;
   logic       load, calc, b_rest_zero, count_last, calc_end;

   assign mulreq_rdy  = (state_q == ST_IDLE);
   assign mulresp_val = (state_q == ST_DONE);
   assign load        = mulreq_rdy & mulreq_val;
   assign calc        = (state_q == ST_CALC);
   assign calc_end    = count_last | ((EARLY_TERM != 0) & b_rest_zero);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (mulreq_val)  state_d = ST_CALC;
         ST_CALC: if (calc_end)    state_d = ST_DONE;
         // Completing a response always passes through IDLE before the next
         // request can be taken.
         ST_DONE: if (mulresp_rdy) state_d = ST_IDLE;
         default:                  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   imuldiv_int_mul_var_dpath #(.W(W)) dpath (
      .clk         (clk),
      .reset       (reset),
      .load        (load),
      .calc        (calc),
      .a_in        (mulreq_msg_a),
      .b_in        (mulreq_msg_b),
      .fn_in       (mulreq_msg_fn),
      .b_rest_zero (b_rest_zero),
      .count_last  (count_last),
      .result      (mulresp_msg_result)
   );

endmodule

// File: doc/imuldiv_int_mul_var.md
IMULDIV_INT_MUL_VAR -- requirements
Module: imuldiv_int_mul_var

Interface
REQ-001: Parameter W SHALL default to 32 and sets the operand width; legal values are 8..64, even.
REQ-002: Parameter EARLY_TERM SHALL default to 1; when 1, iteration stops once the remaining multiplier bits are zero.
REQ-003: Port clk SHALL be input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004: Port reset SHALL be input, 1 bit; reset is synchronous and active-high.
REQ-005: Port mulreq_msg_a SHALL be input, W bits, the multiplicand.
REQ-006: Port mulreq_msg_b SHALL be input, W bits, the multiplier.
REQ-007: Port mulreq_msg_fn SHALL be input, 2 bits: 00 signed×signed, 01 unsigned×unsigned, 10 signed(a)×unsigned(b), 11 treated as 01.
REQ-008: Port mulreq_val SHALL be input, 1 bit, request valid.
REQ-009: Port mulreq_rdy SHALL be output, 1 bit, request ready.
REQ-010: Port mulresp_msg_result SHALL be output, 2W bits, the full product.
REQ-011: Port mulresp_val SHALL be output, 1 bit, response valid.
REQ-012: Port mulresp_rdy SHALL be input, 1 bit, response ready.

Function
REQ-013: The controller SHALL use three states: IDLE, CALC and DONE.
REQ-014: mulreq_rdy SHALL be 1 only in IDLE; mulresp_val SHALL be 1 only in DONE.
REQ-015: Request acceptance (IDLE, val&rdy) SHALL capture magnitudes and sign flags per fn, clear the accumulator and the counter, and go to CALC.
  - A signed operand is negated iff its MSB is 1.
  - Unsigned operands are never negated; their sign flag is 0.
REQ-016: Each CALC cycle SHALL perform the following, with the count in clog2(W) bits.
  - If b_reg[0] is 1, add a_reg (2W bits) to the accumulator.
  - Shift a_reg left and b_reg right by 1.
  - Increment the count.
REQ-017: CALC SHALL go to DONE after the cycle where count==W-1, or, if EARLY_TERM=1, after the cycle where the shifted b value is zero; a minimum of one CALC cycle always occurs.
REQ-018: Latency SHALL be as follows, measured from the acceptance edge at cycle t.
  - EARLY_TERM=0: mulresp_val first high in cycle t+W+1.
  - EARLY_TERM=1: mulresp_val first high in cycle t+k+1, where k = max(1, index of the highest set bit of |b| + 1).
REQ-019: The result SHALL equal the two's-complement negation of the accumulator when sign_a XOR sign_b is 1, and the accumulator otherwise, computed modulo 2^2W.
REQ-020: In DONE, the result and mulresp_val SHALL hold stable until mulresp_rdy=1; on val&rdy the block returns to IDLE.
REQ-021: A new request SHALL NOT be accepted in the cycle a response completes; acceptance earliest occurs in the following IDLE cycle.
REQ-022: The most-negative operand (MSB=1, rest 0) SHALL be handled as magnitude 2^(W-1) without overflow.
REQ-023: Request inputs SHALL be ignored outside IDLE.

Reset
REQ-024: With reset=1 at a clock edge, the state SHALL become IDLE, and the count, a_reg, b_reg, accumulator and sign flags SHALL become 0.
REQ-025: After reset, outputs SHALL be mulreq_rdy=1, mulresp_val=0 and mulresp_msg_result=0.
REQ-026: Reset during CALC or DONE SHALL abort the operation with no response issued.

Structure
REQ-027: The fn encodings (SS, UU, SU) and the state encodings SHALL live in a shared imuldiv package.
REQ-028: The datapath SHALL be one sub-module, imuldiv_int_mul_var_dpath, driven by control in the top module.

Verification
REQ-029: The bench SHALL cover W=32, EARLY_TERM=1, fn=00, a=0xFFFFFFFD, b=5 -> result 0xFFFFFFFFFFFFFFF1, with mulresp_val high at t+4.
REQ-030: The bench SHALL cover W=32, fn=01, a=b=0xFFFFFFFF -> result 0xFFFFFFFE00000001, with mulresp_val high at t+33.
REQ-031: The bench SHALL cover fn=10, a=0xFFFFFFFF, b=0xFFFFFFFF -> result 0xFFFFFFFF00000001; and fn=00, a=b=0x80000000 -> result 0x4000000000000000.
REQ-032: The bench SHALL cover b=0, EARLY_TERM=1 -> result 0, with mulresp_val high at t+2; and the same case with EARLY_TERM=0 -> mulresp_val high at t+33.
REQ-033: The bench SHALL hold mulresp_rdy=0 for 5 cycles in DONE -> result and mulresp_val stable, and mulreq_rdy=0 throughout.
REQ-034: The bench SHALL assert reset at CALC count 10 -> IDLE the next cycle, mulresp_val never high, and the next request computes correctly.
